// File: rtl/mul_div_unit.sv
// Purpose : iterative RV32M multiply/divide unit for the EX stage, one radix-2 step per cycle.
// Latency : 34 cycles issue-to-DoneE (33 stall cycles); div-by-zero/overflow (and fast MUL) take 2.
// Backpr. : holds F/D/E via StallReqE while working; FlushE aborts at any point with no DoneE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   StartE, Funct3E     M-op valid in EX and its funct3 (MUL..REMU)
//   SrcAE, SrcBE        forwarded rs1/rs2 operands
//   FlushE              EX flush; beats StartE and completion
//   StallReqE           (IDLE & StartE) | BUSY
//   DoneE, ResultE      one-cycle result strobe and rd value (held between strobes)
//
// Build option: define MDU_FAST_MUL_EN for a single-cycle combinational multiplier;
// divides stay iterative either way.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallReqE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opa_q, opa_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi, multiplier/lo}; div: {rem, dividend/quot}
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------- issue-time decode ----------------
  logic            is_div_in, a_s_in, b_s_in, neg_a_in, neg_b_in, neg_in;
  logic            div_zero_in, div_ovf_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  always_comb begin
    is_div_in   = Funct3E[2];
    // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed; DIV/REM both.
    a_s_in      = is_div_in ? ~Funct3E[0] : (Funct3E[1:0] != 2'b11);
    b_s_in      = is_div_in ? ~Funct3E[0] : ~Funct3E[1];
    neg_a_in    = a_s_in & SrcAE[XLEN-1];
    neg_b_in    = b_s_in & SrcBE[XLEN-1];
    mag_a_in    = neg_a_in ? -SrcAE : SrcAE;
    mag_b_in    = neg_b_in ? -SrcBE : SrcBE;
    // Remainder follows the dividend's sign; product and quotient follow the sign XOR.
    neg_in      = (is_div_in & Funct3E[1]) ? neg_a_in : (neg_a_in ^ neg_b_in);
    div_zero_in = (SrcBE == ZERO);
    div_ovf_in  = a_s_in & (SrcAE == MIN_NEG) & (SrcBE == ALL_ONES);
  end

`ifdef MDU_FAST_MUL_EN
  // Operands are sign/zero-extended by one bit so one signed multiplier covers all four forms;
  // only the low 2*XLEN bits of the product are ever needed.
  logic signed [XLEN:0]     fast_a, fast_b;
  logic        [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_a    = {a_s_in & SrcAE[XLEN-1], SrcAE};
    fast_b    = {b_s_in & SrcBE[XLEN-1], SrcBE};
    fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
  end
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current multiplier bit is set,
    // then shift the whole accumulator right, consuming that bit.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Restoring divide: shift {rem, dividend} left by one and try to subtract the divisor.
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opa_q};
    div_ge    = (div_trial >= {1'b0, opa_q});
    div_next  = div_ge ? {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1}
                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // ---------------- completion fix-up ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res_sel;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                res_sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:        res_sel = quot_fix;
      default:               res_sel = rem_fix;
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (StartE) begin
          op_d  = Funct3E;
          neg_d = neg_in;
          cnt_d = '0;
          if (is_div_in) begin
            opa_d   = mag_b_in;
            acc_d   = {ZERO, mag_a_in};
            state_d = S_BUSY;
            // Special divides preload the accumulator so the normal fix-up yields the answer.
            if (div_zero_in) begin
              acc_d   = {SrcAE, ALL_ONES};
              neg_d   = 1'b0;
              state_d = S_DONE;
            end else if (div_ovf_in) begin
              acc_d   = {ZERO, MIN_NEG};
              neg_d   = 1'b0;
              state_d = S_DONE;
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc_d   = fast_prod;
            neg_d   = 1'b0;
            state_d = S_DONE;
`else
            opa_d   = mag_a_in;
            acc_d   = {ZERO, mag_b_in};
            state_d = S_BUSY;
`endif
          end
        end
      end
      S_BUSY: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE: begin
        // The same instruction is still in EX here, so StartE is not looked at.
        result_d = res_sel;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over issue and completion alike.
    if (FlushE) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign StallReqE = ((state_q == S_IDLE) & StartE) | (state_q == S_BUSY);
  assign DoneE     = (state_q == S_DONE) & ~FlushE;
  assign ResultE   = (state_q == S_DONE) ? res_sel : result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose : self-checking bench for mul_div_unit (directed table, corner sequences, random vs model).
// Latency : expects 34-cycle normal ops, 2-cycle special divides (and fast MUL when enabled).
// Backpr. : StartE is held until DoneE, mimicking an instruction stalled in EX.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 2;

  logic        clk, rst_n, StartE, FlushE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        StallReqE, DoneE;
  logic [31:0] ResultE;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallReqE(StallReqE), .DoneE(DoneE), .ResultE(ResultE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: RV32M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 32'd0) return SPC_LAT;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPC_LAT;
    return DIV_LAT;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the edge that ends the DONE cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stalls,
                       output int done_cyc);
    StartE = 1'b1; Funct3E = f; SrcAE = a; SrcBE = b;
    lat = -1; stalls = 0; res = '0; done_cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (StallReqE) stalls++;
      if (DoneE) begin
        lat = k; res = ResultE; done_cyc = cyc;
      end
      step();
      if (lat > 0) break;
    end
    StartE = 1'b0;
  endtask

  task automatic watch(input int n, output int dones, output int stalls);
    dones = 0; stalls = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (DoneE) dones++;
      if (StallReqE) stalls++;
      step();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] res, res2;
  int lat, st, dc, dc2, dn;

  initial begin
    rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; Funct3E = '0; SrcAE = '0; SrcBE = '0;

    add_vec(3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    add_vec(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    add_vec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    add_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    add_vec(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    add_vec(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    add_vec(3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    add_vec(3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    add_vec(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
    add_vec(3'd7, 32'd5,         32'd0,         32'd5,         SPC_LAT);
    add_vec(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SPC_LAT);
    add_vec(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPC_LAT);
    add_vec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPC_LAT);
    add_vec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    add_vec(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall",  StallReqE, 0);
    chk("reset_done",   DoneE,     0);
    chk("reset_result", ResultE,   0);
    step();
    rst_n = 1'b1;
    step();

    // Directed table
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, st, dc);
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_stalls", i), st, vecs[i].lat - 1);
    end

    // ResultE holds after DONE
    issue(3'd5, 32'd100, 32'd7, res, lat, st, dc);
    @(negedge clk);
    chk("hold_result", ResultE, 32'd14);
    chk("hold_done",   DoneE,   0);
    step();

    // Flush in the 10th cycle after issue (a BUSY cycle)
    StartE = 1'b1; Funct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (9) step();
    FlushE = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", StallReqE, 1);
    step();
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", StallReqE, 0);
    step();
    watch(40, dn, st);
    chk("flush_no_done", dn, 0);
    issue(3'd5, 32'd9, 32'd3, res, lat, st, dc);
    chk("post_flush_result",  res, 32'd3);
    chk("post_flush_latency", lat, DIV_LAT);

    // Flush in the issue cycle prevents issue
    StartE = 1'b1; FlushE = 1'b1; Funct3E = 3'd4; SrcAE = 32'd100; SrcBE = 32'd7;
    step();
    StartE = 1'b0; FlushE = 1'b0;
    watch(40, dn, st);
    chk("flush_issue_done",  dn, 0);
    chk("flush_issue_stall", st, 0);

    // Flush in the DONE cycle suppresses DoneE
    StartE = 1'b1; Funct3E = 3'd5; SrcAE = 32'd5; SrcBE = 32'd0;
    step();
    FlushE = 1'b1;
    @(negedge clk);
    chk("flush_done_strobe", DoneE, 0);
    step();
    FlushE = 1'b0; StartE = 1'b0;
    watch(5, dn, st);
    chk("flush_done_later", dn, 0);

    // Asynchronous reset in the middle of BUSY
    StartE = 1'b1; Funct3E = 3'd0; SrcAE = 32'd11; SrcBE = 32'd13;
    repeat (5) step();
    #2;
    rst_n = 1'b0; StartE = 1'b0;
    #1;
    chk("rst_mid_stall",  StallReqE, 0);
    chk("rst_mid_done",   DoneE,     0);
    chk("rst_mid_result", ResultE,   0);
    step();
    step();
    rst_n = 1'b1;
    watch(40, dn, st);
    chk("rst_mid_no_done", dn, 0);

    // Back-to-back MULs
    issue(3'd0, 32'h7, 32'hFFFF_FFFD, res,  lat, st, dc);
    issue(3'd0, 32'd5, 32'd6,         res2, lat, st, dc2);
    chk("b2b_first",   res,  32'hFFFF_FFEB);
    chk("b2b_second",  res2, 32'd30);
    chk("b2b_spacing", dc2 - dc, MUL_LAT);

    // Random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      issue(f, a, b, res, lat, st, dc);
      chk($sformatf("rnd%0d_f%0d_%h_%h_result", n, f, a, b), res, ref_model(f, a, b));
      chk($sformatf("rnd%0d_latency", n), lat, ref_lat(f, a, b));
      chk($sformatf("rnd%0d_stalls", n), st, ref_lat(f, a, b) - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
